instr_cycle_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the accumulator micro.
- Sits between program memory, the IR/PC and the accumulator datapath; it is the single source of the datapath strobes.
- Owns a memory request/acknowledge handshake with a timeout, a halt state and a fault state, plus a retired-instruction counter.

---
 rtl/micro_pkg.sv | 56 +++++
 rtl/opcode_decoder.sv | 58 +++++
 rtl/instr_cycle_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the accumulator micro: opcodes, datapath select
// encodings, sequencer states and the EXEC strobe bundle.
package micro_pkg;

  // Opcodes carried in IR[11:8]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_NOR   = 4'h3;
  localparam logic [3:0] OP_MOVRS = 4'h4;
  localparam logic [3:0] OP_MOVRD = 4'h5;
  localparam logic [3:0] OP_JZR   = 4'h6;
  localparam logic [3:0] OP_JZI   = 4'h7;
  localparam logic [3:0] OP_JCR   = 4'h8;
  localparam logic [3:0] OP_RSV9  = 4'h9;
  localparam logic [3:0] OP_JCI   = 4'hA;
  localparam logic [3:0] OP_SHL   = 4'hB;
  localparam logic [3:0] OP_SHR   = 4'hC;
  localparam logic [3:0] OP_LDI   = 4'hD;
  localparam logic [3:0] OP_RSVE  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // SelALU: op in bits [3:2], shift control in bits [1:0]
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SHL  = 4'b0001;
  localparam logic [3:0] ALU_SHR  = 4'b0011;

  // SelAcc: accumulator source
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOADIR,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_FAULT
  } seq_state_e;

  // Datapath strobes driven during the single EXEC cycle
  typedef struct packed {
    logic       inc_pc;
    logic       sel_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
  } exec_strobes_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: maps Opcode plus the Z/C flags to the
// strobe bundle for one EXEC cycle. A not-taken branch advances the PC.
module opcode_decoder
  import micro_pkg::*;
(
  input  logic [3:0]    opcode_i,
  input  logic          z_i,
  input  logic          c_i,
  output exec_strobes_t strobes_o
);

  // Decode one instruction into its EXEC-cycle strobes
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    strobes_o = '0;
    case (opcode_i)
      OP_NOP, OP_RSV9, OP_RSVE: strobes_o.inc_pc = 1'b1;
      OP_ADD, OP_SUB, OP_NOR: begin
        strobes_o.sel_alu  = (opcode_i == OP_ADD) ? ALU_ADD :
                             (opcode_i == OP_SUB) ? ALU_SUB : ALU_NOR;
        strobes_o.sel_acc  = ACC_ALU;
        strobes_o.load_acc = 1'b1;
        strobes_o.inc_pc   = 1'b1;
      end
      OP_MOVRS: begin
        strobes_o.sel_acc  = ACC_REG;
        strobes_o.load_acc = 1'b1;
        strobes_o.inc_pc   = 1'b1;
      end
      OP_MOVRD: begin
        strobes_o.load_reg = 1'b1;
        strobes_o.inc_pc   = 1'b1;
      end
      OP_JZR, OP_JZI, OP_JCR, OP_JCI: begin
        // Register-sourced targets are JZR/JCR; flag is Z for JZx, C for JCx
        if ((opcode_i == OP_JZR || opcode_i == OP_JZI) ? z_i : c_i) begin
          strobes_o.load_pc = 1'b1;
          strobes_o.sel_pc  = (opcode_i == OP_JZR || opcode_i == OP_JCR);
        end else begin
          strobes_o.inc_pc  = 1'b1;
        end
      end
      OP_SHL, OP_SHR: begin
        strobes_o.sel_alu  = (opcode_i == OP_SHL) ? ALU_SHL : ALU_SHR;
        strobes_o.load_acc = 1'b1;
        strobes_o.inc_pc   = 1'b1;
      end
      OP_LDI: begin
        strobes_o.sel_acc  = ACC_IMM;
        strobes_o.load_acc = 1'b1;
        strobes_o.inc_pc   = 1'b1;
      end
      default: strobes_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator micro. Every output is
// a flop loaded from the next state, so each output lines up with the state
// it belongs to and no input reaches an output without a register.
module instr_cycle_sequencer
  import micro_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int RET_W       = 16
) (
  input  logic             clk,
  input  logic             CLB,
  input  logic [3:0]       Opcode,
  input  logic             Z,
  input  logic             C,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelAcc,
  output logic [3:0]       SelALU,
  output logic             halted,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [RET_W-1:0] retired_q, retired_d;
  exec_strobes_t strb_q, strb_d, dec_strb;
  logic          mem_req_q, mem_req_d;
  logic          load_ir_q, load_ir_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;

  opcode_decoder u_dec (
    .opcode_i  (Opcode),
    .z_i       (Z),
    .c_i       (C),
    .strobes_o (dec_strb)
  );

  // Next-state logic and registered-output preload
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH: begin
        // Only an ack against a live request counts; the first cycle after
        // reset has no request outstanding yet.
        if (mem_req_q) begin
          if (mem_ack) begin
            state_d = ST_LOADIR;
            tmo_d   = '0;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_FAULT;
            tmo_d   = '0;
          end else begin
            tmo_d   = tmo_q + 8'd1;
          end
        end
      end
      ST_LOADIR: state_d = ST_DECODE;
      ST_DECODE: state_d = (Opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        state_d   = ST_FETCH;
        retired_d = retired_q + RET_W'(1);
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase

    mem_req_d = (state_d == ST_FETCH);
    load_ir_d = (state_d == ST_LOADIR);
    strb_d    = (state_d == ST_EXEC) ? dec_strb : '0;
    halted_d  = (state_d == ST_HALT);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, counters and output flops with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (CLB) begin
      state_q   <= ST_FETCH;
      tmo_q     <= '0;
      retired_q <= '0;
      strb_q    <= '0;
      mem_req_q <= 1'b0;
      load_ir_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      strb_q    <= strb_d;
      mem_req_q <= mem_req_d;
      load_ir_q <= load_ir_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_req = mem_req_q;
  assign LoadIR  = load_ir_q;
  assign IncPC   = strb_q.inc_pc;
  assign SelPC   = strb_q.sel_pc;
  assign LoadPC  = strb_q.load_pc;
  assign LoadReg = strb_q.load_reg;
  assign LoadAcc = strb_q.load_acc;
  assign SelAcc  = strb_q.sel_acc;
  assign SelALU  = strb_q.sel_alu;
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed bench for instr_cycle_sequencer with a 4-bit retired counter.
module tb_instr_cycle_sequencer;

  localparam int RET_W = 4;

  logic             clk = 1'b0;
  logic             CLB = 1'b1;
  logic [3:0]       Opcode = '0;
  logic             Z = 1'b0;
  logic             C = 1'b0;
  logic             mem_ack = 1'b0;
  logic             mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]       SelAcc;
  logic [3:0]       SelALU;
  logic             halted, fault;
  logic [RET_W-1:0] retired;

  int tests_run = 0;
  int tests_failed = 0;
  logic [RET_W-1:0] exp_ret = '0;

  instr_cycle_sequencer #(.ACK_TIMEOUT(15), .RET_W(RET_W)) dut (
    .clk     (clk),
    .CLB     (CLB),
    .Opcode  (Opcode),
    .Z       (Z),
    .C       (C),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .LoadIR  (LoadIR),
    .IncPC   (IncPC),
    .SelPC   (SelPC),
    .LoadPC  (LoadPC),
    .LoadReg (LoadReg),
    .LoadAcc (LoadAcc),
    .SelAcc  (SelAcc),
    .SelALU  (SelALU),
    .halted  (halted),
    .fault   (fault),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // Observed EXEC bundle: {IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU}
  logic [10:0] obs;
  assign obs = {IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU};

  function automatic logic [10:0] mk(input logic inc, input logic sp, input logic lp,
                                     input logic lr, input logic la,
                                     input logic [1:0] sa, input logic [3:0] alu);
    return {inc, sp, lp, lr, la, sa, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first mem_req cycle of FETCH; ends in the next one.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic z,
                           input logic c, input int wait_n, input logic [10:0] exp);
    repeat (wait_n) tick();
    Opcode = op; Z = z; C = c; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "/loadir"}, {31'd0, LoadIR}, 1);
    check({tag, "/loadir_req"}, {31'd0, mem_req}, 0);
    tick();
    check({tag, "/decode"}, {20'd0, LoadIR, obs}, 0);
    tick();
    check({tag, "/exec"}, {21'd0, obs}, {21'd0, exp});
    check({tag, "/pc_excl"}, {31'd0, LoadPC & IncPC}, 0);
    check({tag, "/load_onehot"}, {31'd0, ($countones({LoadIR, LoadAcc, LoadReg, LoadPC}) <= 1)}, 1);
    check({tag, "/ret_hold"}, {28'd0, retired}, {28'd0, exp_ret});
    tick();
    exp_ret = exp_ret + 4'd1;
    check({tag, "/retired"}, {28'd0, retired}, {28'd0, exp_ret});
    check({tag, "/refetch"}, {20'd0, mem_req, obs}, {20'd0, 1'b1, 11'd0});
  endtask

  task automatic do_reset();
    CLB = 1'b1;
    tick();
    CLB = 1'b0;
    exp_ret = '0;
    check("rst/outputs", {16'd0, mem_req, LoadIR, obs, halted, fault}, 0);
    check("rst/retired", {28'd0, retired}, 0);
    tick();
    check("rst/req_rise", {31'd0, mem_req}, 1);
  endtask

  initial begin
    int req_seen;

    do_reset();

    // Main opcode table; ADD acks in the 2nd request cycle
    run_instr("add",   4'h1, 0, 0, 1, mk(1,0,0,0,1,2'b00,4'b1000));
    run_instr("jzi_t", 4'h7, 1, 0, 0, mk(0,0,1,0,0,2'b00,4'b0000));
    run_instr("jzi_n", 4'h7, 0, 1, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    run_instr("jcr_t", 4'h8, 0, 1, 2, mk(0,1,1,0,0,2'b00,4'b0000));
    run_instr("rsv9",  4'h9, 1, 1, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    run_instr("rsve",  4'hE, 1, 1, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    run_instr("sub",   4'h2, 0, 0, 0, mk(1,0,0,0,1,2'b00,4'b1100));
    run_instr("nor",   4'h3, 0, 0, 0, mk(1,0,0,0,1,2'b00,4'b0100));
    run_instr("movrs", 4'h4, 0, 0, 0, mk(1,0,0,0,1,2'b01,4'b0000));
    run_instr("movrd", 4'h5, 0, 0, 3, mk(1,0,0,1,0,2'b00,4'b0000));
    run_instr("jci_n", 4'hA, 1, 0, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    run_instr("jci_t", 4'hA, 0, 1, 0, mk(0,0,1,0,0,2'b00,4'b0000));
    run_instr("jzr_t", 4'h6, 1, 0, 0, mk(0,1,1,0,0,2'b00,4'b0000));
    run_instr("shl",   4'hB, 0, 0, 0, mk(1,0,0,0,1,2'b00,4'b0001));
    run_instr("shr",   4'hC, 0, 0, 0, mk(1,0,0,0,1,2'b00,4'b0011));
    run_instr("ldi",   4'hD, 0, 0, 0, mk(1,0,0,0,1,2'b10,4'b0000));

    // Timeout: now in request cycle 1; no fault through request cycle 15
    repeat (14) tick();
    check("tmo/edge_nofault", {30'd0, fault, mem_req}, {30'd0, 1'b0, 1'b1});
    tick();
    check("tmo/fault", {31'd0, fault}, 1);
    check("tmo/quiet", {19'd0, mem_req, LoadIR, obs, halted}, 0);
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    check("tmo/late_ack", {30'd0, fault, LoadIR}, {30'd0, 1'b1, 1'b0});
    do_reset();
    check("tmo/cleared", {31'd0, fault}, 0);

    // HALT: straight from DECODE, no retire, no further requests
    Opcode = 4'hF; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("halt/halted", {31'd0, halted}, 1);
    check("halt/quiet", {19'd0, mem_req, LoadIR, obs, fault}, 0);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) mem_ack = 1'b1;
      tick();
      if (mem_req || LoadIR || !halted) req_seen++;
    end
    mem_ack = 1'b0;
    check("halt/no_req_20", req_seen, 0);
    check("halt/retired", {28'd0, retired}, 0);

    // Reset during LOADIR after one retired NOP
    do_reset();
    run_instr("nop", 4'h0, 0, 0, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("midrst/loadir", {31'd0, LoadIR}, 1);
    do_reset();

    // Retired counter wraps: 17 NOPs from zero leave 1 in a 4-bit counter
    for (int i = 0; i < 17; i++)
      run_instr("wrap_nop", 4'h0, 0, 0, 0, mk(1,0,0,0,0,2'b00,4'b0000));
    check("wrap/final", {28'd0, retired}, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the sequence above stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
